// File: rtl/count_sched_pkg.sv
// Shared types and helpers for the count job scheduler.
// Holds the FSM state encoding and the id-width helper.
package count_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int MAX_NREQ  = 4;

  // Id width for n requesters, never below one bit
  function automatic int sched_idw(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/count_rr_arb.sv
// Combinational round-robin grant for the count job scheduler.
// Searches upward from rr_ptr with wrap; enable gates all grants.
module count_rr_arb
  import count_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = sched_idw(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gnt_id
);

  // Walk farthest-first so the slot nearest rr_ptr wins last
  always_comb begin
    int idx;
    grant  = '0;
    gnt_id = '0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (enable && req_valid[idx]) begin
        grant  = NREQ'(1) << idx;
        gnt_id = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/count_job_sched.sv
// Shared compare-and-wrap counter engine, round-robin over requesters.
// One job in flight: counts 0..term, then pulses done for a cycle.
module count_job_sched
  import count_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*WIDTH-1:0]      req_term,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       abort,
  output logic [WIDTH-1:0]           cnt_out,
  output logic                       busy,
  output logic [sched_idw(NREQ)-1:0] busy_id,
  output logic                       done_valid,
  output logic [sched_idw(NREQ)-1:0] done_id
);

  localparam int IDW = sched_idw(NREQ);

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] term_q;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gid;
  logic [IDW-1:0]   ptr_nxt;
  logic [NREQ-1:0]  grant;
  logic             arb_en;
  logic             hs;
  logic             at_term;

  // Grants only while idle, out of reset and not cancelled
  assign arb_en = rst_n & ~abort & (state == ST_IDLE);

  count_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .enable    (arb_en),
    .grant     (grant),
    .gnt_id    (gid)
  );

  assign req_ready  = grant;
  assign hs         = |grant;
  assign at_term    = (cnt == term_q);
  assign ptr_nxt    = (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
  assign cnt_out    = cnt;
  assign done_valid = (state == ST_DONE);
  assign done_id    = done_valid ? id_q : '0;

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: if (hs) nxt = ST_RUN;
      ST_RUN: begin
        if (abort) nxt = ST_IDLE;
        else if (at_term) nxt = ST_DONE;
      end
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      term_q  <= '0;
      id_q    <= '0;
      rr_ptr  <= '0;
      busy    <= 1'b0;
      busy_id <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (hs) begin
            term_q  <= req_term[int'(gid)*WIDTH +: WIDTH];
            id_q    <= gid;
            cnt     <= '0;
            rr_ptr  <= ptr_nxt;
            busy    <= 1'b1;
            busy_id <= gid;
          end
        end
        ST_RUN: begin
          // Compare before increment, so term at full scale never wraps
          if (abort) begin
            cnt     <= '0;
            busy    <= 1'b0;
            busy_id <= '0;
          end else if (!at_term) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          cnt     <= '0;
          busy    <= 1'b0;
          busy_id <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_count_job_sched.sv
// Bench for count_job_sched: job table, corner sequences, random model.
// Two requesters, 8-bit counter.
module tb_count_job_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_term = '0;
  logic        abort = 1'b0;
  logic [1:0]  req_ready;
  logic [7:0]  cnt_out;
  logic        busy;
  logic [0:0]  busy_id;
  logic        done_valid;
  logic [0:0]  done_id;

  int n_pass = 0;
  int n_total = 0;

  count_job_sched #(
    .WIDTH (8),
    .NREQ  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_term   (req_term),
    .req_ready  (req_ready),
    .abort      (abort),
    .cnt_out    (cnt_out),
    .busy       (busy),
    .busy_id    (busy_id),
    .done_valid (done_valid),
    .done_id    (done_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v;
    logic [7:0] t0;
    logic [7:0] t1;
    logic       ab;
    logic [1:0] rdy;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered one cycle after the handshake edge
  task automatic run_job(input string nm, input int id, input int term);
    int bad;
    bad = 0;
    for (int k = 0; k <= term; k++) begin
      if (cnt_out !== 8'(k) || busy !== 1'b1 || busy_id !== 1'(id) ||
          done_valid !== 1'b0 || req_ready !== 2'b00) bad++;
      tick;
    end
    chk({nm, " run cycles"}, bad, 0);
    chk({nm, " done_valid"}, done_valid, 1);
    chk({nm, " done_id"}, done_id, id);
    chk({nm, " done ready"}, req_ready, 0);
    tick;
    chk({nm, " idle done_valid"}, done_valid, 0);
    chk({nm, " idle busy"}, busy, 0);
    chk({nm, " idle busy_id"}, busy_id, 0);
    chk({nm, " idle cnt"}, cnt_out, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int       id;
    int       term;
    int       m_busy;
    int       m_k;
    int       m_term;
    int       m_id;
    int       m_ptr;
    int       ph;
    int       found;
    logic [1:0] exp_rdy;

    tbl[0] = '{2'b01, 8'd3,   8'd0, 1'b0, 2'b01};
    tbl[1] = '{2'b10, 8'd0,   8'd0, 1'b0, 2'b10};
    tbl[2] = '{2'b11, 8'd1,   8'd1, 1'b0, 2'b01};
    tbl[3] = '{2'b11, 8'd1,   8'd1, 1'b0, 2'b10};
    tbl[4] = '{2'b11, 8'd1,   8'd1, 1'b0, 2'b01};
    tbl[5] = '{2'b11, 8'd1,   8'd1, 1'b0, 2'b10};
    tbl[6] = '{2'b11, 8'd1,   8'd1, 1'b1, 2'b00};
    tbl[7] = '{2'b01, 8'd255, 8'd0, 1'b0, 2'b01};
    tbl[8] = '{2'b01, 8'd2,   8'd0, 1'b0, 2'b01};
    tbl[9] = '{2'b10, 8'd0,   8'd7, 1'b0, 2'b10};

    // Reset state, with requests pending
    req_valid = 2'b11;
    #3;
    chk("reset ready", req_ready, 0);
    chk("reset cnt", cnt_out, 0);
    chk("reset busy", busy, 0);
    chk("reset busy_id", busy_id, 0);
    chk("reset done_valid", done_valid, 0);
    chk("reset done_id", done_id, 0);
    #9;
    rst_n = 1'b1;
    req_valid = 2'b00;
    tick;

    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].v;
      req_term  = {tbl[i].t1, tbl[i].t0};
      abort     = tbl[i].ab;
      #1;
      chk($sformatf("vec%0d ready", i), req_ready, tbl[i].rdy);
      tick;
      abort = 1'b0;
      if (tbl[i].rdy == 2'b00) begin
        chk($sformatf("vec%0d no job", i), busy, 0);
      end else begin
        id   = tbl[i].rdy[1] ? 1 : 0;
        term = id ? int'(tbl[i].t1) : int'(tbl[i].t0);
        run_job($sformatf("vec%0d", i), id, term);
      end
    end
    req_valid = 2'b00;

    // Abort mid-run, then the other requester gets the next grant
    req_valid = 2'b01;
    req_term  = {8'd0, 8'd10};
    #1;
    chk("abort hs ready", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    tick;
    tick;
    chk("abort pre cnt", cnt_out, 2);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort cnt", cnt_out, 0);
    chk("abort busy", busy, 0);
    chk("abort busy_id", busy_id, 0);
    chk("abort done_valid", done_valid, 0);
    tick;
    chk("abort later done_valid", done_valid, 0);
    req_valid = 2'b11;
    req_term  = {8'd4, 8'd9};
    #1;
    chk("abort next ready", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    run_job("abort next", 1, 4);

    // Abort during the done cycle keeps the pulse
    req_valid = 2'b01;
    req_term  = {8'd0, 8'd0};
    #1;
    chk("done-abort hs ready", req_ready, 2'b01);
    tick;
    chk("done-abort cnt", cnt_out, 0);
    tick;
    abort = 1'b1;
    #1;
    chk("done-abort done_valid", done_valid, 1);
    chk("done-abort done_id", done_id, 0);
    chk("done-abort ready", req_ready, 0);
    tick;
    abort = 1'b0;
    req_valid = 2'b00;
    chk("done-abort idle busy", busy, 0);
    chk("done-abort idle done", done_valid, 0);

    // Async reset mid-run; pointer returns to requester 0
    req_valid = 2'b01;
    req_term  = {8'd0, 8'd20};
    #1;
    chk("rst hs ready", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    repeat (5) tick;
    chk("rst pre cnt", cnt_out, 5);
    req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst cnt", cnt_out, 0);
    chk("rst busy", busy, 0);
    chk("rst busy_id", busy_id, 0);
    chk("rst done_valid", done_valid, 0);
    chk("rst done_id", done_id, 0);
    chk("rst ready", req_ready, 0);
    tick;
    tick;
    #2;
    rst_n = 1'b1;
    #1;
    chk("post rst ready", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    run_job("post rst", 0, 20);

    // Random traffic against a cycle-offset model
    #1;
    rst_n = 1'b0;
    tick;
    #1;
    rst_n = 1'b1;
    tick;
    m_busy = 0;
    m_k    = 0;
    m_term = 0;
    m_id   = 0;
    m_ptr  = 0;
    for (int c = 0; c < 1500; c++) begin
      req_valid = 2'($urandom);
      req_term[7:0]  = ($urandom_range(0, 9) == 0) ?
                       8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5));
      req_term[15:8] = ($urandom_range(0, 9) == 0) ?
                       8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5));
      abort = ($urandom_range(0, 15) == 0);
      #1;
      if (m_busy == 0) ph = 0;
      else if (m_k <= m_term + 1) ph = 1;
      else ph = 2;
      exp_rdy = 2'b00;
      found = 0;
      if (ph == 0 && !abort) begin
        for (int j = 0; j < 2; j++) begin
          if (found == 0 && req_valid[(m_ptr + j) % 2]) begin
            exp_rdy = 2'b01 << ((m_ptr + j) % 2);
            found = 1;
          end
        end
      end
      chk($sformatf("rnd%0d ready", c), req_ready, exp_rdy);
      chk($sformatf("rnd%0d busy", c), busy, m_busy);
      chk($sformatf("rnd%0d busy_id", c), busy_id, m_busy ? m_id : 0);
      chk($sformatf("rnd%0d done_valid", c), done_valid, ph == 2);
      chk($sformatf("rnd%0d done_id", c), done_id, ph == 2 ? m_id : 0);
      if (ph != 2)
        chk($sformatf("rnd%0d cnt", c), cnt_out, ph == 1 ? m_k - 1 : 0);
      if (ph == 0) begin
        if (exp_rdy != 2'b00) begin
          m_id   = exp_rdy[1] ? 1 : 0;
          m_term = m_id ? int'(req_term[15:8]) : int'(req_term[7:0]);
          m_busy = 1;
          m_k    = 1;
          m_ptr  = (m_id + 1) % 2;
        end
      end else if (ph == 1) begin
        if (abort) m_busy = 0;
        else m_k++;
      end else begin
        m_busy = 0;
      end
      tick;
    end
    abort = 1'b0;
    req_valid = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
